// File: rtl/pipe_skid_stage.sv
// Two-entry skid buffer between pipeline stages. in_ready comes straight from a
// register, so no combinational path runs from out_ready back upstream.
module pipe_skid_stage #(
  parameter int unsigned DATA_W   = 160,
  parameter int unsigned CNT_W    = 16,
  parameter bit          CLR_ZERO = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   main_q, main_d;
  logic [DATA_W-1:0]   skid_q, skid_d;
  logic                in_ready_q;
  logic                in_fire, out_fire;
  logic [CNT_W-1:0]    stall_q, flush_q, flush_d;
  logic [CNT_W:0]      flush_sum;

  assign out_valid = (state_q != EMPTY);
  assign in_ready  = in_ready_q;
  assign in_fire   = in_valid & in_ready_q;
  assign out_fire  = out_valid & out_ready;
  assign out_data  = main_q;
  assign occupancy = 2'(state_q);
  assign stall_cnt = stall_q;
  assign flush_cnt = flush_q;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (clr) begin
      state_d = EMPTY;
      if (CLR_ZERO) begin
        main_d = '0;
        skid_d = '0;
      end
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (in_fire) begin
            main_d  = in_data;
            state_d = ONE;
          end
        end
        ONE: begin
          if (in_fire && out_fire) begin
            main_d = in_data;
          end else if (in_fire) begin
            skid_d  = in_data;
            state_d = FULL;
          end else if (out_fire) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          if (out_fire) begin
            main_d  = skid_q;
            state_d = ONE;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  // Flush count adds the pre-flush occupancy with a carry bit for saturation.
  always_comb begin
    flush_sum = {1'b0, flush_q} + (CNT_W + 1)'(occupancy);
    flush_d   = flush_q;
    if (clr) begin
      flush_d = flush_sum[CNT_W] ? '1 : flush_sum[CNT_W-1:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= EMPTY;
      main_q     <= '0;
      skid_q     <= '0;
      in_ready_q <= 1'b0;
      stall_q    <= '0;
      flush_q    <= '0;
    end else begin
      state_q    <= state_d;
      main_q     <= main_d;
      skid_q     <= skid_d;
      in_ready_q <= (state_d != FULL);
      flush_q    <= flush_d;
      if (out_valid && !out_ready && (stall_q != '1)) begin
        stall_q <= stall_q + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Randomized check of pipe_skid_stage against a queue-based model, plus
// directed scenarios with hand-computed expectations.
module tb_pipe_skid_stage;

  localparam int unsigned DW   = 16;
  localparam int unsigned CW   = 4;
  localparam int          CMAX = 15;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          clr = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_data;
  logic [1:0]    occupancy;
  logic [CW-1:0] stall_cnt;
  logic [CW-1:0] flush_cnt;

  int unsigned n_pass = 0;
  int unsigned n_total = 0;

  pipe_skid_stage #(
    .DATA_W  (DW),
    .CNT_W   (CW),
    .CLR_ZERO(1'b1)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .clr      (clr),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .occupancy(occupancy),
    .stall_cnt(stall_cnt),
    .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  // Reference model: a FIFO of accepted payloads capped at two entries.
  logic [DW-1:0] mq[$];
  bit            m_ready = 1'b0;
  bit            m_zero  = 1'b1;
  int            m_stall = 0;
  int            m_flush = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq.delete();
      m_ready = 1'b0;
      m_zero  = 1'b1;
      m_stall = 0;
      m_flush = 0;
    end else begin
      bit acc, dlv;
      acc = in_valid && m_ready;
      dlv = (mq.size() > 0) && out_ready;
      if ((mq.size() > 0) && !out_ready && m_stall < CMAX) m_stall = m_stall + 1;
      if (clr) begin
        m_flush = m_flush + mq.size();
        if (m_flush > CMAX) m_flush = CMAX;
        mq.delete();
        m_zero  = 1'b1;
        m_ready = 1'b1;
      end else begin
        if (dlv) void'(mq.pop_front());
        if (acc) begin
          mq.push_back(in_data);
          m_zero = 1'b0;
        end
        m_ready = (mq.size() != 2);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  always @(negedge clk) begin
    chk("m_in_ready", 32'(in_ready), 32'(m_ready));
    chk("m_out_valid", 32'(out_valid), 32'(mq.size() > 0));
    chk("m_occupancy", 32'(occupancy), 32'(mq.size()));
    chk("m_stall_cnt", 32'(stall_cnt), 32'(m_stall));
    chk("m_flush_cnt", 32'(flush_cnt), 32'(m_flush));
    if (mq.size() > 0) chk("m_out_data", 32'(out_data), 32'(mq[0]));
    else if (m_zero) chk("m_out_data_zero", 32'(out_data), 32'd0);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // reset state
    #2;
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_occupancy", 32'(occupancy), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    tick();
    rst = 1'b0;
    tick();
    chk("rel_in_ready", 32'(in_ready), 32'd1);

    // streaming 1..4
    in_valid = 1'b1; out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      in_data = 16'(i);
      tick();
      chk("str_data", 32'(out_data), 32'(i));
      chk("str_occ", 32'(occupancy), 32'd1);
    end
    in_valid = 1'b0;
    tick();
    chk("str_drain_occ", 32'(occupancy), 32'd0);

    // backpressure
    out_ready = 1'b0; in_valid = 1'b1; in_data = 16'h00A0;
    tick();
    in_data = 16'h00B0;
    tick();
    chk("bp_occ", 32'(occupancy), 32'd2);
    chk("bp_ready", 32'(in_ready), 32'd0);
    chk("bp_hold", 32'(out_data), 32'h00A0);
    chk("bp_stall1", 32'(stall_cnt), 32'd1);
    in_valid = 1'b0;
    tick();
    chk("bp_stall2", 32'(stall_cnt), 32'd2);
    chk("bp_hold2", 32'(out_data), 32'h00A0);
    tick();
    chk("bp_stall3", 32'(stall_cnt), 32'd3);
    out_ready = 1'b1;
    tick();
    chk("bp_second", 32'(out_data), 32'h00B0);
    chk("bp_ready_back", 32'(in_ready), 32'd1);
    tick();
    chk("bp_empty", 32'(occupancy), 32'd0);

    // flush while FULL with C presented
    out_ready = 1'b0; in_valid = 1'b1; in_data = 16'h00A1;
    tick();
    in_data = 16'h00B1;
    tick();
    clr = 1'b1; in_data = 16'h00C1;
    tick();
    clr = 1'b0; in_valid = 1'b0;
    chk("fl_occ", 32'(occupancy), 32'd0);
    chk("fl_valid", 32'(out_valid), 32'd0);
    chk("fl_data", 32'(out_data), 32'd0);
    chk("fl_cnt", 32'(flush_cnt), 32'd2);
    chk("fl_ready", 32'(in_ready), 32'd1);
    chk("fl_stall", 32'(stall_cnt), 32'd5);

    // simultaneous accept and deliver in ONE
    in_valid = 1'b1; in_data = 16'h00A2;
    tick();
    in_data = 16'h00B2; out_ready = 1'b1;
    tick();
    chk("sim_data", 32'(out_data), 32'h00B2);
    chk("sim_occ", 32'(occupancy), 32'd1);
    in_valid = 1'b0;
    tick();
    chk("sim_drain", 32'(occupancy), 32'd0);

    // stall counter saturation
    out_ready = 1'b0; in_valid = 1'b1; in_data = 16'h0077;
    tick();
    in_valid = 1'b0;
    repeat (20) tick();
    chk("sat_stall", 32'(stall_cnt), 32'd15);

    // async reset mid-cycle while FULL
    out_ready = 1'b1; in_valid = 1'b1; in_data = 16'h0011;
    tick();
    out_ready = 1'b0; in_data = 16'h0022;
    tick();
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("ar_occ", 32'(occupancy), 32'd0);
    chk("ar_valid", 32'(out_valid), 32'd0);
    chk("ar_data", 32'(out_data), 32'd0);
    chk("ar_ready", 32'(in_ready), 32'd0);
    chk("ar_stall", 32'(stall_cnt), 32'd0);
    chk("ar_flush", 32'(flush_cnt), 32'd0);
    tick();
    rst = 1'b0;
    tick();
    chk("ar_ready_rel", 32'(in_ready), 32'd1);

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = 16'($urandom);
      out_ready = ($urandom_range(0, 2) != 0);
      clr       = ($urandom_range(0, 39) == 0);
      tick();
    end
    clr = 1'b0; in_valid = 1'b0;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/pipe_skid_stage.md
PIPE_SKID_STAGE -- requirements
Module: pipe_skid_stage

Interface
REQ-001 Parameter DATA_W, default 160, width of the payload carried between pipeline stages (control bundle plus results).
REQ-002 Parameter CNT_W, default 16, width of each statistics counter.
REQ-003 Parameter CLR_ZERO, default 1, 1 = clr zeroes the data registers, 0 = clr invalidates entries only.
REQ-004 clk  input  1  single clock; every register samples on the rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 clr  input  1  synchronous flush; the stage discards all contents.
REQ-007 in_valid  input  1  upstream presents a valid payload.
REQ-008 in_ready  output  1  stage accepts a payload this cycle; driven directly from a register.
REQ-009 in_data  input  DATA_W  upstream payload.
REQ-010 out_valid  output  1  out_data holds a valid payload.
REQ-011 out_ready  input  1  downstream accepts out_data this cycle.
REQ-012 out_data  output  DATA_W  payload from the head register.
REQ-013 occupancy  output  2  number of held entries: 0, 1 or 2.
REQ-014 stall_cnt  output  CNT_W  cycles with out_valid=1 and out_ready=0.
REQ-015 flush_cnt  output  CNT_W  valid entries discarded by clr.

Function
REQ-016 The stage SHALL define in_fire = in_valid & in_ready and out_fire = out_valid & out_ready.
REQ-017 The stage SHALL hold two storage registers: main, which drives out_data, and skid.
REQ-018 The stage SHALL implement states EMPTY (occupancy 0), ONE (occupancy 1) and FULL (occupancy 2).
REQ-019 EMPTY: on in_fire, in_data SHALL load into main and the state SHALL go to ONE; otherwise the state SHALL stay EMPTY.
REQ-020 ONE, in_fire and out_fire together: main SHALL load in_data and the state SHALL stay ONE.
REQ-021 ONE, in_fire only: in_data SHALL load into skid and the state SHALL go to FULL.
REQ-022 ONE, out_fire only: the state SHALL go to EMPTY.
REQ-023 FULL: in_ready SHALL be 0; on out_fire, skid SHALL move into main and the state SHALL go to ONE.
REQ-024 in_ready SHALL equal (next state != FULL), registered; in_ready SHALL have no combinational path from out_ready.
REQ-025 out_valid SHALL equal (state != EMPTY); occupancy SHALL encode the state.
REQ-026 Latency into an empty stage SHALL be one cycle: in_fire in cycle N gives out_valid=1 with that data in cycle N+1.
REQ-027 Payloads SHALL leave in acceptance order, with no loss and no duplication.
REQ-028 out_data SHALL stay stable while out_valid=1 and out_ready=0.
REQ-029 clr SHALL take priority over all handshakes in the same cycle.
REQ-030 On clr: the next state SHALL be EMPTY and in_ready SHALL be 1 in the next cycle.
REQ-031 On clr: if CLR_ZERO=1, main and skid SHALL be zeroed.
REQ-032 On clr: in_data presented in that cycle SHALL be dropped, and out_fire in that cycle SHALL NOT count as delivered.
REQ-033 On clr, flush_cnt SHALL add the occupancy held before the flush, saturating at all-ones.
REQ-034 stall_cnt SHALL increment by 1 in each cycle with out_valid=1 and out_ready=0, saturating at all-ones.
REQ-035 clr SHALL NOT affect stall_cnt; clr SHALL NOT clear flush_cnt.
REQ-036 When DATA_W=1, behaviour SHALL be identical to wider widths.

Reset
REQ-037 While rst=1, regardless of clk: state=EMPTY, out_valid=0, out_data=0, skid=0, occupancy=0, stall_cnt=0, flush_cnt=0.
REQ-038 While rst=1, in_ready SHALL be 0; in_ready SHALL become 1 on the first rising clk edge after rst deasserts.
REQ-039 rst asserted during a transfer SHALL discard every entry immediately without updating the counters.

Verification
REQ-040 Streaming: out_ready=1, in_valid=1, data 1,2,3,4 -> out_data 1,2,3,4 on consecutive cycles starting one cycle later; occupancy stays 1.
REQ-041 Backpressure: load A, B with out_ready=0 -> occupancy 2, in_ready=0, out_data=A held, stall_cnt climbs by 1 per cycle; release out_ready -> A then B, in_ready back to 1 one cycle after A leaves.
REQ-042 Flush: FULL with A and B, assert clr while in_valid=1 with C -> next cycle occupancy 0, out_valid=0, out_data=0, flush_cnt=2; C is never output.
REQ-043 Simultaneous: ONE holding A, in_fire with B and out_fire in the same cycle -> next cycle out_data=B, occupancy 1, A delivered exactly once.
REQ-044 Saturation: CNT_W=4, hold a stall for 20 cycles -> stall_cnt stops at 15.
REQ-045 Async reset: assert rst mid-cycle while FULL -> outputs reach reset values before the next clk edge; in_ready=1 after the first edge following release.
